// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Byte-stream loader that fills IMEM and releases the core after a
//            checksum-verified image has been written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  localparam int          C_IDX_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  localparam logic [2:0] S_LEN  = 3'd0;
  localparam logic [2:0] S_DATA = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]         r_state;
  logic               r_live;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_shift;
  logic [C_IDX_W-1:0] r_widx;
  logic [C_IDX_W-1:0] r_len;
  logic [7:0]         r_xor;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;

  logic               w_accepting;
  logic               w_fire;
  logic               w_last_byte;
  logic [31:0]        w_word;
  logic [C_IDX_W-1:0] w_widx_next;
  logic [31:0]        w_offset;

  assign w_accepting = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  // r_live keeps in_ready low until the first edge after reset is released
  assign in_ready    = r_live && w_accepting;
  assign w_fire      = in_valid && in_ready;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  // The three earlier bytes sit in r_shift, so the current byte completes the word
  assign w_word      = {in_data, r_shift};
  assign w_widx_next = r_widx + 1'b1;
  assign w_offset    = {{(32 - C_IDX_W - 2){1'b0}}, r_widx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_LEN;
      r_live     <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_widx     <= '0;
      r_len      <= '0;
      r_xor      <= 8'd0;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= 32'd0;
    end else begin
      r_live <= 1'b1;
      r_we   <= 1'b0;
      case (r_state)
        S_LEN: begin
          if (w_fire) begin
            r_shift    <= {in_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              if (w_word > C_DEPTH) begin
                r_state <= S_ERR;
              end else if (w_word == 32'd0) begin
                r_state <= S_CHK;
              end else begin
                r_len   <= w_word[C_IDX_W-1:0];
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_fire) begin
            r_shift    <= {in_data, r_shift[23:8]};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_xor      <= r_xor ^ in_data;
            if (w_last_byte) begin
              r_we    <= 1'b1;
              r_addr  <= BASE_ADDR + w_offset;
              r_wdata <= w_word;
              r_widx  <= w_widx_next;
              if (w_widx_next == r_len) begin
                r_state <= S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          if (w_fire) begin
            r_state <= (in_data == r_xor) ? S_DONE : S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
            r_widx     <= '0;
            r_len      <= '0;
            r_xor      <= 8'd0;
          end
        end
        default: r_state <= S_LEN;
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = (r_state == S_DONE);
  assign error      = (r_state == S_ERR);
  // Only a verified image lets the core run
  assign core_rst   = (r_state != S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Self-checking bench for imem_boot_loader with an image-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] img [0:DEPTH-1];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          acc_q     [$];

  always @(posedge clk) cyc <= cyc + 1;

  // IMEM-side view: every cycle with the strobe high is one captured word
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [7:0] model_xor(input int n);
    logic [7:0] x = 8'd0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++)
        x ^= img[i][8*b +: 8];
    return x;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_byte_timeout in_ready=%b required 1", in_ready);
    end else begin
      @(negedge clk);
      acc_q.push_back(cyc);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_image(input int n, input logic [7:0] flip, input bit gaps);
    logic [31:0] len;
    len = 32'(n);
    for (int b = 0; b < 4; b++) send_byte(len[8*b +: 8], gaps);
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gaps);
    send_byte(model_xor(n) ^ flip, gaps);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_program1();
    img[0] = 32'h0050_0093;
    img[1] = 32'h0010_8113;
  endtask

  // status = {core_rst, done, error, in_ready}
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, BASE, 32'd0}) begin
      n_err++;
      $display("FAIL reset_wr_port got we=%b addr=%h data=%h", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_status got=%b exp=1000", {core_rst, done, error, in_ready});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_edge got=%b exp=0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_edge got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_valid_image();
    load_program1();
    clear_log();
    send_image(2, 8'h00, 1'b0);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b0100) begin
      n_err++;
      $display("FAIL t1_status got=%b exp=0100", {core_rst, done, error, in_ready});
    end
    n_cmp++;
    if (wr_addr_q.size() != 2) begin
      n_err++;
      $display("FAIL t1_nwrites got=%0d exp=2", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (wr_addr_q[i] !== BASE + 32'(4*i) || wr_data_q[i] !== img[i]) begin
          n_err++;
          $display("FAIL t1_write%0d got=%h:%h exp=%h:%h", i, wr_addr_q[i], wr_data_q[i],
                   BASE + 32'(4*i), img[i]);
        end
        // strobe belongs to the cycle right after the word's 4th byte is taken
        n_cmp++;
        if (wr_cyc_q[i] != acc_q[4 + 4*i + 3]) begin
          n_err++;
          $display("FAIL t1_wr_timing%0d got=%0d exp=%0d", i, wr_cyc_q[i], acc_q[4 + 4*i + 3]);
        end
      end
    end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1001) begin
      n_err++;
      $display("FAIL t2_rearm got=%b exp=1001", {core_rst, done, error, in_ready});
    end
    load_program1();
    clear_log();
    send_image(2, 8'h03, 1'b0);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1010) begin
      n_err++;
      $display("FAIL t2_status got=%b exp=1010", {core_rst, done, error, in_ready});
    end
    n_cmp++;
    if (wr_addr_q.size() != 2 || wr_data_q[0] !== img[0] || wr_data_q[1] !== img[1]) begin
      n_err++;
      $display("FAIL t2_writes got_n=%0d exp_n=2", wr_addr_q.size());
    end
  endtask

  task automatic test_empty();
    pulse_start();
    clear_log();
    send_image(0, 8'h00, 1'b0);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b0100) begin
      n_err++;
      $display("FAIL t3_status got=%b exp=0100", {core_rst, done, error, in_ready});
    end
    n_cmp++;
    if (wr_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL t3_nwrites got=%0d exp=0", wr_addr_q.size());
    end
  endtask

  task automatic test_oversize();
    logic [31:0] len;
    pulse_start();
    clear_log();
    len = 32'(DEPTH + 1);
    for (int b = 0; b < 4; b++) send_byte(len[8*b +: 8], 1'b0);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1010) begin
      n_err++;
      $display("FAIL t4_status got=%b exp=1010", {core_rst, done, error, in_ready});
    end
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1010 || wr_addr_q.size() != 0) begin
      n_err++;
      $display("FAIL t4_hold got=%b writes=%0d exp=1010 writes=0",
               {core_rst, done, error, in_ready}, wr_addr_q.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse_start();
    load_program1();
    for (int b = 0; b < 4; b++) send_byte((b == 0) ? 8'h02 : 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) send_byte(img[k/4][8*(k%4) +: 8], 1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, BASE, 32'd0}) begin
      n_err++;
      $display("FAIL t5_wr_port got we=%b addr=%h data=%h", imem_we, imem_addr, imem_wdata);
    end
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL t5_status got=%b exp=1000", {core_rst, done, error, in_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    send_image(2, 8'h00, 1'b0);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b0100) begin
      n_err++;
      $display("FAIL t5_reload got=%b exp=0100", {core_rst, done, error, in_ready});
    end
    n_cmp++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== BASE || wr_data_q[0] !== img[0]) begin
      n_err++;
      $display("FAIL t5_first_write n=%0d exp n=2 at %h", wr_addr_q.size(), BASE);
    end
  endtask

  task automatic test_reload_stalls();
    pulse_start();
    n_cmp++;
    if (core_rst !== 1'b1) begin
      n_err++;
      $display("FAIL t6_core_rst got=%b exp=1", core_rst);
    end
    img[0] = 32'hDEAD_BEEF;
    clear_log();
    send_image(1, 8'h00, 1'b1);
    n_cmp++;
    if ({core_rst, done, error, in_ready} !== 4'b0100) begin
      n_err++;
      $display("FAIL t6_status got=%b exp=0100", {core_rst, done, error, in_ready});
    end
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== BASE || wr_data_q[0] !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL t6_write n=%0d exp 1 write of deadbeef", wr_addr_q.size());
    end
  endtask

  task automatic test_random(input int iters, input bit full_depth);
    int          n;
    logic [7:0]  flip;
    bit          gaps;
    for (int it = 0; it < iters; it++) begin
      n    = full_depth ? DEPTH : int'($urandom_range(1, 8));
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      gaps = full_depth ? 1'b0 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) img[i] = $urandom;
      pulse_start();
      clear_log();
      send_image(n, flip, gaps);
      n_cmp++;
      if ({core_rst, done, error, in_ready} !== ((flip == 8'h00) ? 4'b0100 : 4'b1010)) begin
        n_err++;
        $display("FAIL rnd%0d_status got=%b flip=%h n=%0d", it, {core_rst, done, error, in_ready},
                 flip, n);
      end
      n_cmp++;
      if (wr_addr_q.size() != n) begin
        n_err++;
        $display("FAIL rnd%0d_nwrites got=%0d exp=%0d", it, wr_addr_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          n_cmp++;
          if (wr_addr_q[i] !== BASE + 32'(4*i) || wr_data_q[i] !== img[i]) begin
            n_err++;
            $display("FAIL rnd%0d_write%0d got=%h:%h exp=%h:%h", it, i, wr_addr_q[i],
                     wr_data_q[i], BASE + 32'(4*i), img[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_image();
    test_bad_checksum();
    test_empty();
    test_oversize();
    test_async_reset();
    test_reload_stalls();
    test_random(8, 1'b0);
    test_random(1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
